// File: rtl/sram_boot_config.sv
// Boot loader: reads NBYTES config bytes from SRAM while holding the core in reset, then hands the bus over.
// Bus select and master_reset_n come from registered state, so the bus changes hands on one clean edge.
module sram_boot_config #(
  parameter int                  NBYTES      = 2,
  parameter int                  ADDR_W      = 21,
  parameter logic [ADDR_W-1:0]   BASE_ADDR   = 21'h008FD5,
  parameter int                  SETTLE      = 4,
  parameter int                  HOLD        = 4,
  parameter int                  NTOGGLE     = 2,
  parameter logic [8*NBYTES-1:0] DEFAULT_CFG = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     core_sram_addr,
  input  logic                  core_sram_we_n,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic                  sram_we_n,
  input  logic [7:0]            sram_data_in,
  output logic                  master_reset_n,
  output logic                  busy,
  output logic [8*NBYTES-1:0]   cfg,
  output logic                  cfg_valid,
  input  logic [NTOGGLE-1:0]    toggle_tg,
  output logic [NTOGGLE-1:0]    mode
);

  localparam int CNT_MAX = (SETTLE > HOLD) ? SETTLE : HOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {LOAD, HOLDRST, RUN} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [NBYTES-1:0][7:0]  shadow;
  logic [NTOGGLE-1:0]      tg_s1, tg_s2, tg_prev, inv;
  logic                    core_owns;
  logic [ADDR_W-1:0]       boot_addr;

  // idx parks on the last byte during HOLDRST, so the address holds there too
  assign boot_addr = BASE_ADDR + ADDR_W'(idx);
  assign sram_addr = core_owns ? core_sram_addr : boot_addr;
  assign sram_we_n = core_owns ? core_sram_we_n : 1'b1;
  assign mode      = cfg[NTOGGLE-1:0] ^ inv;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= LOAD;
      cnt            <= '0;
      idx            <= '0;
      shadow         <= '0;
      inv            <= '0;
      tg_s1          <= '0;
      tg_s2          <= '0;
      tg_prev        <= '0;
      cfg            <= DEFAULT_CFG;
      cfg_valid      <= 1'b0;
      core_owns      <= 1'b0;
      master_reset_n <= 1'b0;
      busy           <= 1'b1;
    end else begin
      tg_s1   <= toggle_tg;
      tg_s2   <= tg_s1;
      tg_prev <= tg_s2;
      case (state)
        LOAD: begin
          if (cnt == CW'(SETTLE - 1)) begin
            shadow[idx] <= sram_data_in;
            cnt         <= '0;
            if (idx == IW'(NBYTES - 1)) state <= HOLDRST;
            else                        idx   <= idx + IW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLDRST: begin
          // An all-0xFF block means erased/uninitialised SRAM: keep the defaults
          if (cnt == '0 && !(&shadow)) begin
            cfg       <= shadow;
            cfg_valid <= 1'b1;
          end
          if (cnt == CW'(HOLD - 1)) begin
            state          <= RUN;
            cnt            <= '0;
            core_owns      <= 1'b1;
            master_reset_n <= 1'b1;
            busy           <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          inv <= inv ^ (tg_s2 & ~tg_prev);
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_boot_config.sv
// Bench for sram_boot_config: two parameterisations, expected waveforms derived from the boot timing rules.
module tb_sram_boot_config;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  localparam int N0 = 2, S0 = 4, H0 = 4;
  localparam logic [15:0] DEF0  = 16'h0002;
  localparam logic [20:0] BASE0 = 21'h008FD5;

  logic        reset0;
  logic [20:0] core_addr0, sram_addr0;
  logic        core_we0, sram_we0, mrst0, busy0, valid0;
  logic [7:0]  din0;
  logic [15:0] cfg0;
  logic [1:0]  tg0, mode0;
  logic [7:0]  mem0 [2];
  logic [15:0] exp_cfg0;

  always_comb begin
    din0 = 8'h5A;
    if (sram_addr0 == BASE0)              din0 = mem0[0];
    else if (sram_addr0 == BASE0 + 21'd1) din0 = mem0[1];
  end

  sram_boot_config #(.NBYTES(2), .ADDR_W(21), .BASE_ADDR(21'h008FD5), .SETTLE(4), .HOLD(4),
                     .NTOGGLE(2), .DEFAULT_CFG(16'h0002)) u0 (
    .clk(clk), .reset(reset0), .core_sram_addr(core_addr0), .core_sram_we_n(core_we0),
    .sram_addr(sram_addr0), .sram_we_n(sram_we0), .sram_data_in(din0),
    .master_reset_n(mrst0), .busy(busy0), .cfg(cfg0), .cfg_valid(valid0),
    .toggle_tg(tg0), .mode(mode0));

  localparam logic [20:0] BASE1 = 21'h1FFFFE;

  logic        reset1;
  logic [20:0] core_addr1, sram_addr1;
  logic        core_we1, sram_we1, mrst1, busy1, valid1;
  logic [7:0]  din1;
  logic [31:0] cfg1;
  logic [1:0]  tg1, mode1;
  logic [7:0]  mem1 [4];

  always_comb begin
    din1 = 8'hA5;
    for (int i = 0; i < 4; i++)
      if (sram_addr1 == 21'(BASE1 + 21'(i))) din1 = mem1[i];
  end

  sram_boot_config #(.NBYTES(4), .ADDR_W(21), .BASE_ADDR(21'h1FFFFE), .SETTLE(1), .HOLD(1),
                     .NTOGGLE(2), .DEFAULT_CFG(32'h0)) u1 (
    .clk(clk), .reset(reset1), .core_sram_addr(core_addr1), .core_sram_we_n(core_we1),
    .sram_addr(sram_addr1), .sram_we_n(sram_we1), .sram_data_in(din1),
    .master_reset_n(mrst1), .busy(busy1), .cfg(cfg1), .cfg_valid(valid1),
    .toggle_tg(tg1), .mode(mode1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Resets u0, boots it from {b1,b0} and checks every output on every edge through handover.
  task automatic boot_check0(input logic [7:0] b0, input logic [7:0] b1, input bit load_pulse);
    int          byte_i;
    bit          in_run, cfg_live;
    logic [15:0] c_exp;
    mem0[0] = b0;
    mem0[1] = b1;
    core_addr0 = 21'h12345;
    core_we0   = 1'b0;
    tg0        = 2'b00;
    exp_cfg0   = (b0 == 8'hFF && b1 == 8'hFF) ? DEF0 : {b1, b0};
    reset0 = 1'b1;
    tick();
    reset0 = 1'b0;
    for (int k = 0; k <= N0 * S0 + H0 + 2; k++) begin
      if (k > 0) tick();
      if (load_pulse) tg0 = (k == 2 || k == 3) ? 2'b01 : 2'b00;
      byte_i   = (k < N0 * S0) ? k / S0 : N0 - 1;
      in_run   = (k >= N0 * S0 + H0);
      cfg_live = (k >= N0 * S0 + 1);
      c_exp    = cfg_live ? exp_cfg0 : DEF0;
      check("boot_addr", 32'(sram_addr0), in_run ? 32'h12345 : 32'(BASE0 + 21'(byte_i)));
      check("boot_we_n", 32'(sram_we0), in_run ? 32'd0 : 32'd1);
      check("boot_mrst_n", 32'(mrst0), 32'(in_run));
      check("boot_busy", 32'(busy0), 32'(!in_run));
      check("boot_cfg", 32'(cfg0), 32'(c_exp));
      check("boot_cfg_valid", 32'(valid0), 32'(cfg_live && exp_cfg0 == {b1, b0}));
      check("boot_mode", 32'(mode0), 32'(c_exp[1:0]));
    end
  endtask

  // Random hotkey pulses in RUN; each flips its mode bits exactly on the third edge.
  task automatic run_toggles(input int n);
    logic [1:0] inv, mask;
    inv = 2'b00;
    for (int p = 0; p < n; p++) begin
      mask = 2'($urandom_range(1, 3));
      core_addr0 = 21'($urandom);
      core_we0   = 1'($urandom);
      #1;
      check("pass_addr", 32'(sram_addr0), 32'(core_addr0));
      check("pass_we_n", 32'(sram_we0), 32'(core_we0));
      tg0 = mask;
      tick();
      check("tg_edge1", 32'(mode0), 32'(exp_cfg0[1:0] ^ inv));
      tick();
      check("tg_edge2", 32'(mode0), 32'(exp_cfg0[1:0] ^ inv));
      tg0 = 2'b00;
      tick();
      inv = inv ^ mask;
      check("tg_edge3", 32'(mode0), 32'(exp_cfg0[1:0] ^ inv));
      tick();
      tick();
      check("tg_settled", 32'(mode0), 32'(exp_cfg0[1:0] ^ inv));
      check("run_cfg_frozen", 32'(cfg0), 32'(exp_cfg0));
    end
  endtask

  initial begin
    reset0 = 1'b1; reset1 = 1'b1;
    core_addr0 = 21'h12345; core_we0 = 1'b0; tg0 = 2'b00;
    core_addr1 = 21'($urandom); core_we1 = 1'b1; tg1 = 2'b00;
    mem0[0] = 8'h00; mem0[1] = 8'h00;
    for (int i = 0; i < 4; i++) mem1[i] = 8'($urandom);
    repeat (3) tick();

    check("rst_addr", 32'(sram_addr0), 32'(BASE0));
    check("rst_we_n", 32'(sram_we0), 32'd1);
    check("rst_mrst_n", 32'(mrst0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd1);
    check("rst_cfg", 32'(cfg0), 32'(DEF0));
    check("rst_cfg_valid", 32'(valid0), 32'd0);
    check("rst_mode", 32'(mode0), 32'b10);

    boot_check0(8'h01, 8'h00, 1'b0);
    run_toggles(4);
    boot_check0(8'hFF, 8'hFF, 1'b1);
    run_toggles(3);
    boot_check0(8'hFF, 8'h7E, 1'b0);

    // Reset asserted so that edge 6 of a boot sees it
    reset0 = 1'b1;
    tick();
    reset0 = 1'b0;
    repeat (5) tick();
    reset0 = 1'b1;
    tick();
    check("midload_addr", 32'(sram_addr0), 32'(BASE0));
    check("midload_mrst_n", 32'(mrst0), 32'd0);
    check("midload_busy", 32'(busy0), 32'd1);

    for (int r = 0; r < 3; r++) begin
      boot_check0(8'($urandom), 8'($urandom), r[0]);
      run_toggles(2);
    end

    // Four-byte, single-cycle configuration with address wrap past 2^21
    tick();
    reset1 = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      logic [31:0] fin;
      bit          allff, in_run;
      int          bi;
      if (k > 0) tick();
      fin    = {mem1[3], mem1[2], mem1[1], mem1[0]};
      allff  = (fin == 32'hFFFF_FFFF);
      bi     = (k < 4) ? k : 3;
      in_run = (k >= 5);
      check("w_addr", 32'(sram_addr1), in_run ? 32'(core_addr1) : 32'(21'(BASE1 + 21'(bi))));
      check("w_mrst_n", 32'(mrst1), 32'(in_run));
      check("w_busy", 32'(busy1), 32'(!in_run));
      check("w_we_n", 32'(sram_we1), 32'd1);
      check("w_cfg", cfg1, (k >= 5 && !allff) ? fin : 32'h0);
      check("w_cfg_valid", 32'(valid1), 32'(k >= 5 && !allff));
      check("w_mode", 32'(mode1), (k >= 5 && !allff) ? 32'(fin[1:0]) : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_boot_config.md
# sram_boot_config

Power-on configuration loader and SRAM boot arbiter for the SAM Coupé top level. After reset it takes the SRAM bus and reads a parametrised block of configuration bytes from a fixed SRAM address. It holds the machine in reset while it does so, then hands the bus to the core and releases `master_reset_n`. It also owns the runtime mode-toggle inverters (scandoubler, scanlines, and any further modes) that flip the loaded defaults from core hotkey pulses.

## Interface
Parameters:
- `NBYTES`, 2: number of config bytes read (1..8).
- `ADDR_W`, 21: SRAM address width.
- `BASE_ADDR`, 21'h008FD5: address of config byte 0; byte i is at `BASE_ADDR+i`.
- `SETTLE`, 4: cycles each boot address is held before its byte is sampled (≥1).
- `HOLD`, 4: extra cycles reset is held after the last sample (≥1).
- `NTOGGLE`, 2: number of toggleable mode bits; must be ≤ 8*NBYTES.
- `DEFAULT_CFG`, 0: fallback config, width 8*NBYTES.

Ports:
- `clk` in 1: system clock (clk6 domain at top level).
- `reset` in 1: synchronous, active-high.
- `core_sram_addr` in ADDR_W: address from the core.
- `core_sram_we_n` in 1: write strobe from the core.
- `sram_addr` out ADDR_W: address to the SRAM pins.
- `sram_we_n` out 1: write strobe to the SRAM pins.
- `sram_data_in` in 8: SRAM read data.
- `master_reset_n` out 1: core reset, low while booting.
- `busy` out 1: high while loading or holding.
- `cfg` out 8*NBYTES: loaded config, byte i at bits [8i+7:8i].
- `cfg_valid` out 1: high when the loaded block was not all 0xFF.
- `toggle_tg` in NTOGGLE: asynchronous hotkey pulses from the core.
- `mode` out NTOGGLE: `cfg[NTOGGLE-1:0] ^ inv`.

## Operation
- States: LOAD, HOLDRST, RUN.
- `reset` forces LOAD with byte index 0, settle count 0, `inv`=0, `cfg`=DEFAULT_CFG and `cfg_valid`=0.
- LOAD:
  - `sram_addr` = `BASE_ADDR+idx`, `sram_we_n`=1, `master_reset_n`=0, `busy`=1.
  - The settle count runs 0..SETTLE-1. On the edge where count = SETTLE-1, `sram_data_in` is captured into the shadow byte idx, count clears and idx increments.
  - After byte NBYTES-1 is captured, the state moves to HOLDRST.
- HOLDRST:
  - Bus and reset outputs are the same as in LOAD.
  - The address is held at `BASE_ADDR+NBYTES-1`.
  - The state lasts HOLD cycles.
  - On entry, validation is done: if every shadow byte is 0xFF, `cfg` stays DEFAULT_CFG and `cfg_valid`=0. Otherwise `cfg` takes the shadow value and `cfg_valid`=1.
- RUN:
  - `sram_addr`=`core_sram_addr`, `sram_we_n`=`core_sram_we_n`, `master_reset_n`=1, `busy`=0.
  - The block stays in RUN until `reset`.
- Toggles:
  - Each `toggle_tg[k]` passes through a 2-flop synchroniser and a previous-value flop.
  - A synchronised rising edge in RUN flips `inv[k]`. Edges seen in LOAD or HOLDRST are discarded.
  - Simultaneous edges on different bits flip each bit independently.
- `cfg` never changes in RUN. Only `mode` reflects the toggles.
- Bus writes are never issued during boot.

## Timing
- Reset outputs:
  - `sram_addr`=BASE_ADDR, `sram_we_n`=1, `master_reset_n`=0, `busy`=1.
  - `cfg`=DEFAULT_CFG, `cfg_valid`=0.
  - `mode`=DEFAULT_CFG[NTOGGLE-1:0].
- Byte i is sampled on edge (i+1)*SETTLE after `reset` falls (edge 1 is the first edge with `reset` low).
- `cfg`/`cfg_valid` update on edge NBYTES*SETTLE+1.
- `master_reset_n` and the bus switch to the core on edge NBYTES*SETTLE+HOLD. With defaults this is edge 12.
- Bus mux and `master_reset_n` are registered from state. They switch on the same edge, so there is no cycle with a mixed address.
- A toggle rising edge at the input appears on `mode` 3 edges later. The pulse must be high for ≥1 full clk period to be counted.
- `reset` asserted mid-load or in RUN takes effect on the next edge. The full sequence then restarts from byte 0 and any toggle inversion is lost.
- Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W.

## Test plan
- Defaults with SRAM bytes 0x8FD5=0x01, 0x8FD6=0x00:
  - Address 0x8FD5 is held for edges 1-4 and 0x8FD6 for edges 5-8.
  - `cfg`=16'h0001 and `cfg_valid`=1 from edge 9; `master_reset_n`=1 at edge 12.
- Both SRAM bytes 0xFF with DEFAULT_CFG=16'h0002 → `cfg`=16'h0002, `cfg_valid`=0, `mode`=2'b10.
- In RUN:
  - One 2-cycle pulse on `toggle_tg[0]` flips `mode[0]` 3 edges after the pulse rises.
  - A second pulse restores it.
  - A pulse during LOAD changes nothing.
- Bus handover: `core_sram_we_n`=0 with `core_sram_addr`=0x12345 during LOAD gives `sram_we_n`=1 and `sram_addr`=0x8FD5. In RUN both pass through the same cycle.
- Reset mid-load (asserted on edge 6) → `sram_addr` returns to 0x8FD5, `master_reset_n` stays 0, and the full 12-edge sequence repeats.
- NBYTES=4, SETTLE=1, HOLD=1, BASE_ADDR=21'h1FFFFE:
  - Addresses read are 0x1FFFFE, 0x1FFFFF, 0x000000, 0x000001.
  - `master_reset_n` rises at edge 5.
